// File: rtl/dm_arbiter.sv
// Two-port arbiter for the single-ported data memory: CPU priority, port-1 aging and bounded burst lock.
// Latency: grant and DM drive are combinational; read data returns one cycle after the grant.
// Backpressure: a requester holds req/addr/we/wdata until its gnt; the loser simply waits.
module dm_arbiter #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 16,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic              dm_re,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rd_data
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

    logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
    logic              owner_q, owner_d;
    logic              force_release_q, force_release_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic aging;
    logic p1_wins;
    logic gnt0_c, gnt1_c;
    logic we_sel;
    logic any_gnt;

    always_comb begin
        aging   = (wait_cnt_q == WW'(MAX_WAIT));
        // A pending forced release overrides both aging and the held lock.
        p1_wins = ~force_release_q & (aging | (owner_q & lock1));
        gnt1_c  = rst_n & req1 & (~req0 | p1_wins);
        gnt0_c  = rst_n & req0 & ~gnt1_c;
        any_gnt = gnt0_c | gnt1_c;

        we_sel   = gnt1_c ? we1    : we0;
        dm_addr  = gnt1_c ? addr1  : addr0;
        dm_wdata = gnt1_c ? wdata1 : wdata0;
        dm_re    = any_gnt & ~we_sel;
        dm_we    = any_gnt & we_sel;
    end

    always_comb begin
        wait_cnt_d = '0;
        if (req1 & ~gnt1_c) begin
            wait_cnt_d = aging ? wait_cnt_q : wait_cnt_q + WW'(1);
        end

        owner_d = owner_q;
        if (gnt1_c) begin
            owner_d = 1'b1;
        end else if (gnt0_c) begin
            owner_d = 1'b0;
        end

        // The lock only counts against port 0 while port 0 is actually waiting.
        force_release_d = 1'b0;
        burst_cnt_d     = burst_cnt_q;
        if (gnt1_c & lock1 & req0) begin
            if (burst_cnt_q == BW'(BURST_MAX - 1)) begin
                force_release_d = 1'b1;
                burst_cnt_d     = '0;
            end else begin
                burst_cnt_d = burst_cnt_q + BW'(1);
            end
        end else if (gnt0_c | ~lock1) begin
            burst_cnt_d = '0;
        end

        rvalid0_d = gnt0_c & ~we0;
        rvalid1_d = gnt1_c & ~we1;
        rdata_d   = (rvalid0_d | rvalid1_d) ? dm_rd_data : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q      <= '0;
            burst_cnt_q     <= '0;
            owner_q         <= 1'b0;
            force_release_q <= 1'b0;
            rvalid0_q       <= 1'b0;
            rvalid1_q       <= 1'b0;
            rdata_q         <= '0;
        end else begin
            wait_cnt_q      <= wait_cnt_d;
            burst_cnt_q     <= burst_cnt_d;
            owner_q         <= owner_d;
            force_release_q <= force_release_d;
            rvalid0_q       <= rvalid0_d;
            rvalid1_q       <= rvalid1_d;
            rdata_q         <= rdata_d;
        end
    end

    assign gnt0    = gnt0_c;
    assign gnt1    = gnt1_c;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus random traffic against a cycle-level policy model.
module tb_dm_arbiter;
    localparam int AW = 13;
    localparam int DW = 16;
    localparam int MW = 4;
    localparam int BM = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, dm_re, dm_we;
    logic [DW-1:0] rdata, dm_wdata;
    logic [DW-1:0] dm_rd_data = '0;
    logic [AW-1:0] dm_addr;

    always #5 clk = ~clk;

    dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW), .BURST_MAX(BM)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1), .gnt1(gnt1),
        .rvalid1(rvalid1), .rdata(rdata),
        .dm_addr(dm_addr), .dm_re(dm_re), .dm_we(dm_we), .dm_wdata(dm_wdata), .dm_rd_data(dm_rd_data)
    );

    // Single-ported data memory, sampling on the falling edge.
    logic [DW-1:0] mem [0:8191];
    logic          mem_clr = 1'b1;
    always @(negedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 8192; i++) mem[i] <= '0;
        end else begin
            if (dm_we) mem[dm_addr] <= dm_wdata;
            if (dm_re) dm_rd_data <= mem[dm_addr];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: policy state as plain counters.
    int            m_wait, m_run;
    bit            m_owner, m_force, m_rv0, m_rv1;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] ref_mem [0:8191];
    bit            e0 = 1'b0, e1 = 1'b0;
    bit            obs_g1;

    function automatic void model_reset();
        m_wait = 0; m_run = 0; m_owner = 0; m_force = 0;
        m_rv0 = 0; m_rv1 = 0; m_rdata = '0;
    endfunction

    // Caller sets inputs at posedge+1; returns at the next posedge+1.
    task automatic run_cycle();
        bit            rd, wr, nf;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        #3;
        e1 = req1 && (!req0 || (!m_force && (m_wait == MW || (m_owner && lock1))));
        e0 = req0 && !e1;
        rd = (e0 && !we0) || (e1 && !we1);
        wr = (e0 && we0) || (e1 && we1);
        a  = e1 ? addr1 : addr0;
        wd = e1 ? wdata1 : wdata0;
        obs_g1 = gnt1;
        check("gnt0", gnt0, e0);
        check("gnt1", gnt1, e1);
        check("dm_re", dm_re, rd);
        check("dm_we", dm_we, wr);
        check("dm_addr", dm_addr, a);
        if (wr) check("dm_wdata", dm_wdata, wd);
        check("rvalid0", rvalid0, m_rv0);
        check("rvalid1", rvalid1, m_rv1);
        check("rdata", rdata, m_rdata);

        m_rv0 = e0 && !we0;
        m_rv1 = e1 && !we1;
        if (wr) ref_mem[a] = wd;
        if (rd) m_rdata = ref_mem[a];
        nf = 0;
        if (e1 && lock1 && req0) begin
            m_run++;
            if (m_run == BM) begin nf = 1; m_run = 0; end
        end else if (e0 || !lock1) begin
            m_run = 0;
        end
        if (req1 && !e1) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
        else m_wait = 0;
        if (e0) m_owner = 0;
        else if (e1) m_owner = 1;
        m_force = nf;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req0 = 0; req1 = 0; lock1 = 0;
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, run, maxrun, k, lim;
        for (int i = 0; i < 8192; i++) ref_mem[i] = '0;

        // Reset with both requests high: nothing may be granted.
        req0 = 1; req1 = 1;
        repeat (2) @(posedge clk);
        mem_clr = 0;
        #1;
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_dm_re", dm_re, 0);
        check("rst_dm_we", dm_we, 0);
        check("rst_rvalid", {rvalid0, rvalid1}, 0);
        check("rst_rdata", rdata, 0);
        req0 = 0; req1 = 0;
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();

        // Port 0 write then read back.
        req0 = 1; we0 = 1; addr0 = 13'h0010; wdata0 = 16'h1234;
        run_cycle();
        we0 = 0;
        run_cycle();
        check("p0_rvalid", rvalid0, 1);
        check("p0_rdata", rdata, 16'h1234);
        req0 = 0;
        run_cycle();

        // Reset asserted in the middle of a read grant.
        req0 = 1; we0 = 0; addr0 = 13'h0010;
        #2;
        rst_n = 0;
        #1;
        check("mrst_gnt0", gnt0, 0);
        check("mrst_dm_re", dm_re, 0);
        check("mrst_dm_we", dm_we, 0);
        check("mrst_rdata", rdata, 0);
        @(posedge clk); #1;
        check("mrst_rvalid0", rvalid0, 0);
        check("mrst_rdata2", rdata, 0);
        req0 = 0;
        rst_n = 1;
        model_reset();
        idle(1);

        // Both requesting continuously, no lock: aging gives port 1 every 5th cycle.
        cnt = 0;
        req0 = 1; we0 = 0; addr0 = 13'h0003;
        req1 = 1; we1 = 0; addr1 = 13'h0004; lock1 = 0;
        for (int i = 0; i < 20; i++) begin
            run_cycle();
            if (obs_g1) cnt++;
            if (e0) addr0 = AW'($urandom_range(0, 15));
            if (e1) addr1 = AW'($urandom_range(0, 15));
        end
        check("aging_gnt1_count", cnt, 4);
        idle(2);

        // Locked burst of 16 reads while port 0 keeps requesting.
        k = 0; run = 0; maxrun = 0; lim = 0;
        req1 = 1; we1 = 0; lock1 = 1; addr1 = 13'h1000;
        req0 = 1; we0 = 0; addr0 = AW'($urandom_range(0, 15));
        while (k < 16 && lim < 200) begin
            run_cycle();
            lim++;
            if (obs_g1) begin run++; if (run > maxrun) maxrun = run; end
            else run = 0;
            if (e1) begin k++; addr1 = AW'(13'h1000 + k); end
            if (e0) addr0 = AW'($urandom_range(0, 15));
            if (k == 16) req1 = 0;
        end
        check("burst_done", k, 16);
        check("burst_max_run", maxrun, BM);
        idle(2);

        // Lock with port 0 idle: unlimited.
        cnt = 0;
        req1 = 1; we1 = 0; lock1 = 1;
        for (int i = 0; i < 16; i++) begin
            addr1 = AW'(13'h1000 + i);
            run_cycle();
            if (obs_g1) cnt++;
        end
        check("lock_unlimited", cnt, 16);
        idle(2);

        // Back-to-back reads of the two ports.
        req0 = 1; we0 = 1; addr0 = 13'h0001; wdata0 = 16'hAAAA;
        run_cycle();
        req0 = 0;
        req1 = 1; we1 = 1; addr1 = 13'h0002; wdata1 = 16'h5555;
        run_cycle();
        req0 = 1; we0 = 0; addr0 = 13'h0001;
        req1 = 1; we1 = 0; addr1 = 13'h0002; lock1 = 0;
        run_cycle();
        req0 = 0;
        check("alt_rvalid0", rvalid0, 1);
        check("alt_rdata0", rdata, 16'hAAAA);
        run_cycle();
        req1 = 0;
        check("alt_rvalid", {rvalid0, rvalid1}, 2'b01);
        check("alt_rdata1", rdata, 16'h5555);
        idle(2);

        // Random traffic with hold-until-grant requesters.
        for (int i = 0; i < 1500; i++) begin
            if (!req0 || e0) begin
                req0   = ($urandom_range(0, 9) < 6);
                we0    = 1'($urandom_range(0, 1));
                addr0  = AW'($urandom_range(0, 15));
                wdata0 = DW'($urandom);
            end
            if (!req1 || e1) begin
                req1   = ($urandom_range(0, 9) < 7);
                we1    = 1'($urandom_range(0, 1));
                addr1  = AW'($urandom_range(0, 15));
                wdata1 = DW'($urandom);
                lock1  = ($urandom_range(0, 3) != 0);
            end
            run_cycle();
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
